clahe_clip_cdf: RTL
===================

Name: clahe_clip_cdf

Overview:
Downstream consumer of the per-tile histogram statistics stage. On each frame-histogram-done pulse it walks all 64 tile histograms in the finished bank. For each tile it clips bins at a contrast limit, redistributes the clipped excess uniformly, accumulates the CDF and scales it to an 8-bit mapping LUT. It writes one 256-entry LUT per tile into the LUT RAM used by the pixel-mapping stage, then signals completion.

Parameters:
TILE_NUM, 64, number of tiles processed per frame
BINS, 256, bins per tile histogram (fixed at 256; addresses are 8-bit)
SCALE, 1161, CDF-to-LUT multiplier, round(255*65536/TILE_PIXELS) for 14400-pixel tiles

Ports:
pclk  in  1  clock
rst_n  in  1  asynchronous active-low reset
frame_hist_done  in  1  single-cycle pulse: histogram bank complete, start processing
clip_limit  in  16  per-bin clip threshold, sampled on accepted frame_hist_done
hist_rd_tile_idx  out  6  histogram RAM read tile index
hist_rd_addr  out  8  histogram RAM read bin address
hist_rd_data  in  16  histogram RAM read data, valid 1 cycle after address
lut_wr_tile_idx  out  6  LUT RAM write tile index
lut_wr_addr  out  8  LUT RAM write address (bin)
lut_wr_data  out  8  LUT value
lut_wr_en  out  1  LUT RAM write enable
cdf_busy  out  1  high from start acceptance until cdf_done
cdf_done  out  1  single-cycle pulse: all 64 LUTs written
overrun  out  1  single-cycle pulse: frame_hist_done arrived while busy

Behaviour:
- Reset: all outputs 0, FSM = IDLE, accumulators and counters 0. Reset mid-operation aborts immediately with no further LUT writes. The partially written LUT bank is not restored.
- FSM states: IDLE, CLIP, CALC, MAP, NEXT, DONE.
- IDLE: frame_hist_done (cycle 0) latches clip_limit into clip_r, sets tile=0, cdf_busy=1, goes to CLIP in cycle 1.
- CLIP, 257 cycles:
  - hist_rd_addr = 0..255 on CLIP cycles 0..255; data for bin k sampled on cycle k+1.
  - excess += (bin > clip_r) ? bin - clip_r : 0.
  - excess is 24-bit, cleared on entry to CLIP.
- CALC, 1 cycle: incr = excess[23:8] (16-bit), rem = excess[7:0].
- MAP, 258 cycles:
  - hist_rd_addr = 0..255 again; data for bin k arrives on cycle k+1.
  - new_k = min(bin, clip_r) + incr + (k < rem ? 1 : 0).
  - cdf (24-bit, cleared on entry) += new_k.
  - lut_k = min(255, (cdf_k * SCALE) >> 16), using a 40-bit product.
  - Registered write: lut_wr_en=1 with lut_wr_addr=k, lut_wr_data=lut_k on MAP cycle k+2, i.e. 2 cycles after hist_rd_addr=k.
  - Exactly 256 writes per tile, in address order, with lut_wr_tile_idx = current tile.
- NEXT, 1 cycle: if tile==63 go to DONE, else tile+1 and go to CLIP.
- DONE, 1 cycle: cdf_done=1; cdf_busy falls next cycle; go to IDLE.
- Timing: 517 cycles per tile. cdf_done is asserted exactly 1+64*517 = 33089 cycles after the accepted frame_hist_done. cdf_busy is high over that span inclusive.
- hist_rd_tile_idx equals the current tile in CLIP and MAP. hist_rd_addr holds its last value otherwise. lut_wr_en=0 outside MAP write slots.
- Arithmetic:
  - excess and cdf are 24-bit unsigned and cannot overflow: at most 65535*256 < 2^24.
  - CDF saturation to 255 is mandatory.
- Boundaries:
  - clip_limit=0: every bin is clipped to 0 and the whole tile total is redistributed.
  - clip_limit >= every bin: excess=0, so the output is a plain CDF LUT.
  - rem=0: no extra +1 anywhere.
- frame_hist_done while not IDLE: ignored, clip_r unchanged, overrun pulses for 1 cycle.
- frame_hist_done in the DONE cycle: also treated as overrun. A new start is accepted only in IDLE.

Test Plan:
- Tile 0 bin0=14400, others 0, clip_limit=65535 -> excess=0; every lut[k]=255 (14400*1161>>16 saturates); 256 writes for tile 0.
- Tile 0 bin128=14400, clip_limit=100 -> excess=14300, incr=55, rem=220; new_0=56 so lut[0]=0; new_128=156; lut[255]=255.
- All tiles, every bin=56, clip_limit=65535 -> lut[0]=0, lut[255]=253 (14336*1161>>16); identical LUTs for tiles 0..63.
- Start with all-zero histograms -> cdf_done exactly 33089 cycles after frame_hist_done; 16384 total lut_wr_en pulses; cdf_busy high throughout.
- Second frame_hist_done 1000 cycles after the first -> overrun pulses once; clip_r unchanged; completion timing unaffected.
- rst_n asserted during tile 5 MAP -> all outputs 0 immediately; next frame_hist_done restarts from tile 0 with correct LUTs.

Source files
------------

// File: rtl/clahe_clip_cdf.sv
// Clip-limited CDF stage: walks every tile histogram of a finished bank, clips and
// redistributes excess, accumulates the CDF and writes a 256-entry 8-bit LUT per tile.
module clahe_clip_cdf #(
  parameter int unsigned TILE_NUM = 64,
  parameter int unsigned BINS     = 256,
  parameter int unsigned SCALE    = 1161
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        frame_hist_done,
  input  logic [15:0] clip_limit,
  output logic [5:0]  hist_rd_tile_idx,
  output logic [7:0]  hist_rd_addr,
  input  logic [15:0] hist_rd_data,
  output logic [5:0]  lut_wr_tile_idx,
  output logic [7:0]  lut_wr_addr,
  output logic [7:0]  lut_wr_data,
  output logic        lut_wr_en,
  output logic        cdf_busy,
  output logic        cdf_done,
  output logic        overrun
);

  localparam logic [5:0] LastTile = 6'(TILE_NUM - 1);
  localparam logic [8:0] ClipLast = 9'(BINS);      // final CLIP cycle samples bin 255
  localparam logic [8:0] MapLast  = 9'(BINS + 1);  // final MAP cycle issues write 255
  localparam logic [8:0] AddrLast = 9'(BINS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClip,
    StCalc,
    StMap,
    StNext,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [5:0]  tile_q, tile_d;
  logic [15:0] clip_q, clip_d;
  logic [23:0] excess_q, excess_d;
  logic [15:0] incr_q, incr_d;
  logic [7:0]  rem_q, rem_d;
  logic [23:0] cdf_q, cdf_d;
  logic [7:0]  addr_q, addr_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        overrun_q, overrun_d;

  logic        over_clip;
  logic [15:0] bin_clipped;
  logic [15:0] bin_excess;
  logic [7:0]  map_k;
  logic [23:0] new_val;
  logic [23:0] cdf_sum;
  logic [39:0] prod;
  logic [23:0] scaled;
  logic [7:0]  lut_val;

  always_comb begin
    over_clip   = hist_rd_data > clip_q;
    bin_clipped = over_clip ? clip_q : hist_rd_data;
    bin_excess  = over_clip ? hist_rd_data - clip_q : 16'd0;
    // Data for bin k arrives one cycle after its address, so cnt runs one ahead of k.
    map_k       = 8'(cnt_q - 9'd1);
    new_val     = 24'(bin_clipped) + 24'(incr_q) + 24'(map_k < rem_q);
    cdf_sum     = cdf_q + new_val;
    prod        = 40'(cdf_sum) * 40'(SCALE);
    scaled      = 24'(prod >> 16);
    lut_val     = (|scaled[23:8]) ? 8'hff : scaled[7:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tile_d    = tile_q;
    clip_d    = clip_q;
    excess_d  = excess_q;
    incr_d    = incr_q;
    rem_d     = rem_q;
    cdf_d     = cdf_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    overrun_d = frame_hist_done && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (frame_hist_done) begin
          clip_d   = clip_limit;
          tile_d   = 6'd0;
          cnt_d    = 9'd0;
          excess_d = 24'd0;
          addr_d   = 8'd0;
          state_d  = StClip;
        end
      end
      StClip: begin
        if (cnt_q != 9'd0) excess_d = excess_q + 24'(bin_excess);
        if (cnt_q < AddrLast) addr_d = addr_q + 8'd1;
        if (cnt_q == ClipLast) begin
          cnt_d   = 9'd0;
          state_d = StCalc;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      StCalc: begin
        incr_d  = excess_q[23:8];
        rem_d   = excess_q[7:0];
        cdf_d   = 24'd0;
        addr_d  = 8'd0;
        cnt_d   = 9'd0;
        state_d = StMap;
      end
      StMap: begin
        if (cnt_q != 9'd0 && cnt_q <= ClipLast) begin
          cdf_d     = cdf_sum;
          wr_en_d   = 1'b1;
          wr_addr_d = map_k;
          wr_data_d = lut_val;
        end
        if (cnt_q < AddrLast) addr_d = addr_q + 8'd1;
        if (cnt_q == MapLast) begin
          cnt_d   = 9'd0;
          state_d = StNext;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      StNext: begin
        if (tile_q == LastTile) begin
          state_d = StDone;
        end else begin
          tile_d   = tile_q + 6'd1;
          cnt_d    = 9'd0;
          excess_d = 24'd0;
          addr_d   = 8'd0;
          state_d  = StClip;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 9'd0;
      tile_q    <= 6'd0;
      clip_q    <= 16'd0;
      excess_q  <= 24'd0;
      incr_q    <= 16'd0;
      rem_q     <= 8'd0;
      cdf_q     <= 24'd0;
      addr_q    <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tile_q    <= tile_d;
      clip_q    <= clip_d;
      excess_q  <= excess_d;
      incr_q    <= incr_d;
      rem_q     <= rem_d;
      cdf_q     <= cdf_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      overrun_q <= overrun_d;
    end
  end

  assign hist_rd_tile_idx = tile_q;
  assign hist_rd_addr     = addr_q;
  assign lut_wr_tile_idx  = tile_q;
  assign lut_wr_addr      = wr_addr_q;
  assign lut_wr_data      = wr_data_q;
  assign lut_wr_en        = wr_en_q;
  assign cdf_busy         = state_q != StIdle;
  assign cdf_done         = state_q == StDone;
  assign overrun          = overrun_q;

endmodule
